ixc_deposit_logic: RTL and testbench
====================================

# ixc_deposit_logic

Host-to-design value injector for the emulation sampling interface: takes deposit/force/release requests from the host side, queues them, and applies them to one design signal only on an emulation step-boundary strobe. Return path for the sample latch: the sample logic reads design values out to the host, and this block writes host values back into the design. It sits between the host transaction layer and the instrumented signal, one instance per depositable signal.

## Interface
- WIDTH, 1: width of the instrumented signal.
- DEPTH, 4: request queue entries; power of two, minimum 2.
- clk  input  1  emulation clock; the only clock.
- rst  input  1  reset; synchronous, active-high.
- req_valid  input  1  host request present.
- req_ready  output  1  queue can accept; equals not-full.
- req_op  input  2  00 deposit, 01 force, 10 release, 11 reserved.
- req_data  input  WIDTH  value for deposit/force; ignored for release.
- apply_en  input  1  step-boundary strobe; at most one entry is applied per asserted cycle.
- v  input  WIDTH  design-driven value of the signal.
- dv  output  WIDTH  value delivered to the design: override value when overriding, else v (combinational pass-through).
- dv_en  output  1  override active.
- ack_valid  output  1  one-cycle pulse per applied entry.
- ack_op  output  2  op of the applied entry.
- rb_data  output  WIDTH  readback of v at apply (see Configuration).
- err  output  1  sticky: a reserved op has been applied.

## Operation
- Queue: FIFO of {op, data}, DEPTH entries. Push on req_valid && req_ready. Pop on apply_en && !empty. Pushes while full are impossible because req_ready is low.
- State machine, with registered state and held data hd:
  - IDLE: dv_en=0.
  - PULSE: dv_en=1 for exactly one cycle, dv=hd, then return to IDLE, or to FORCED if forced_flag is set.
  - FORCED: dv_en=1, dv=hd until a release is applied.
- On pop, by op:
  - deposit: hd<=data. From IDLE go to PULSE. From FORCED, stay FORCED with the new hd; the deposit overwrites the forced value.
  - force: hd<=data, go to FORCED.
  - release: go to IDLE. If the block is not in FORCED, no override changes.
  - reserved: no state change; err<=1.
- Every pop sets ack_valid=1 and ack_op=op for one cycle.
- apply_en with an empty queue has no effect: no ack and no state change.
- Reset values: queue empty, state IDLE, hd=0, dv_en=0, dv=v, ack_valid=0, ack_op=0, rb_data=0, err=0, req_ready=1 (from the cycle after reset deasserts). Reset mid-override drops the override and discards all queued entries.

## Timing
- Push in cycle N: the entry becomes eligible for pop in cycle N+1 (no same-cycle bypass).
- Pop in cycle N: dv_en, dv, ack_valid, ack_op and rb_data change at N+1.
- Deposit from IDLE popped in N: dv_en high only in cycle N+1.
- Force popped in N: dv_en high from N+1. Release popped in M: dv_en low from M+1.
- Pop and push in the same cycle are both performed. When the queue is full, req_ready rises the cycle after the pop.
- Consecutive apply_en cycles pop one entry each. Deposit then deposit on back-to-back cycles gives two single-cycle pulses with the second value at N+2.
- Pointers wrap modulo DEPTH. Full/empty are tracked with an extra pointer bit.

## Configuration
- IXC_DEPOSIT_READBACK_EN defined: rb_data registers v (not dv) in the pop cycle, so the host sees the pre-override design value.
- IXC_DEPOSIT_READBACK_EN undefined: rb_data is tied to 0 and no readback register exists. All other behaviour is identical.

## Test plan
- Reset, then deposit 0x1 (WIDTH=1) with apply_en 3 cycles later, v=0 -> dv=1 and dv_en=1 for exactly one cycle; ack_op=00; rb_data=0 with readback enabled.
- Force data=1, hold v=0 over 10 cycles, then release -> dv=1 from force+1 until release+1; then dv follows v.
- WIDTH=8: force 0xA5, deposit 0x3C, release -> dv=0xA5, then 0x3C (still forced), then v after release; three acks in order 01, 00, 10.
- Push 4 entries with no apply_en -> req_ready=0 after the 4th. One apply_en -> req_ready=1 one cycle later. A 5th push then succeeds and all entries drain in FIFO order.
- Apply a reserved op (11) -> err=1 and stays set, ack_op=11, no dv_en change. Release while IDLE -> ack only, no effect.
- Assert rst while FORCED with 2 entries queued -> next cycle dv_en=0, dv=v, err=0, queue empty; subsequent apply_en produces no ack.

Source files
------------

// File: rtl/ixc_deposit_logic.sv
// Host-to-design value injector: queues deposit/force/release requests and applies one per step strobe.
// Optional readback of the pre-override design value: define IXC_DEPOSIT_READBACK_EN.
module ixc_deposit_logic #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_req_valid,
    output logic             o_req_ready,
    input  logic [1:0]       i_req_op,
    input  logic [WIDTH-1:0] i_req_data,
    input  logic             i_apply_en,
    input  logic [WIDTH-1:0] i_v,
    output logic [WIDTH-1:0] o_dv,
    output logic             o_dv_en,
    output logic             o_ack_valid,
    output logic [1:0]       o_ack_op,
    output logic [WIDTH-1:0] o_rb_data,
    output logic             o_err
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned EW = WIDTH + 2;

    localparam logic [1:0] OP_DEPOSIT  = 2'b00;
    localparam logic [1:0] OP_FORCE    = 2'b01;
    localparam logic [1:0] OP_RELEASE  = 2'b10;
    localparam logic [1:0] OP_RESERVED = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_PULSE  = 2'd1,
        S_FORCED = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;

    logic [EW-1:0]    r_mem [DEPTH];
    logic [PW:0]      r_wr_ptr;
    logic [PW:0]      r_rd_ptr;
    logic             w_empty;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [1:0]       w_pop_op;
    logic [WIDTH-1:0] w_pop_data;

    logic [WIDTH-1:0] r_hd;
    logic             r_ack_valid;
    logic [1:0]       r_ack_op;
    logic             r_err;

    // Extra pointer bit separates full from empty when the index bits match
    assign w_empty     = (r_wr_ptr == r_rd_ptr);
    assign w_full      = (r_wr_ptr[PW] != r_rd_ptr[PW]) &&
                         (r_wr_ptr[PW-1:0] == r_rd_ptr[PW-1:0]);
    assign w_push      = i_req_valid && !w_full;
    assign w_pop       = i_apply_en && !w_empty;
    assign o_req_ready = !w_full;

    assign {w_pop_op, w_pop_data} = r_mem[r_rd_ptr[PW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[PW-1:0]] <= {i_req_op, i_req_data};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + (PW+1)'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + (PW+1)'(1);
            end
        end
    end

    // Override state register
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A pulse lasts one cycle unless another deposit lands on it
    always_comb begin
        w_state_nxt = r_state;
        if (r_state == S_PULSE) begin
            w_state_nxt = S_IDLE;
        end
        if (w_pop) begin
            case (w_pop_op)
                OP_DEPOSIT: begin
                    if (r_state != S_FORCED) begin
                        w_state_nxt = S_PULSE;
                    end
                end
                OP_FORCE:   w_state_nxt = S_FORCED;
                OP_RELEASE: w_state_nxt = S_IDLE;
                default:    ;
            endcase
        end
    end

    always_comb begin
        o_dv_en = 1'b0;
        o_dv    = i_v;
        if (r_state != S_IDLE) begin
            o_dv_en = 1'b1;
            o_dv    = r_hd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hd        <= '0;
            r_ack_valid <= 1'b0;
            r_ack_op    <= 2'b00;
            r_err       <= 1'b0;
        end else begin
            r_ack_valid <= w_pop;
            if (w_pop) begin
                r_ack_op <= w_pop_op;
                if ((w_pop_op == OP_DEPOSIT) || (w_pop_op == OP_FORCE)) begin
                    r_hd <= w_pop_data;
                end
                if (w_pop_op == OP_RESERVED) begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    assign o_ack_valid = r_ack_valid;
    assign o_ack_op    = r_ack_op;
    assign o_err       = r_err;

`ifdef IXC_DEPOSIT_READBACK_EN
    logic [WIDTH-1:0] r_rb_data;

    // Capture the design-driven value, not the override, so the host sees pre-override state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rb_data <= '0;
        end else if (w_pop) begin
            r_rb_data <= i_v;
        end
    end

    assign o_rb_data = r_rb_data;
`else
    assign o_rb_data = '0;
`endif

endmodule

// File: tb/tb_ixc_deposit_logic.sv
// Scoreboard bench for ixc_deposit_logic: directed requests, expected acks queued and checked by a monitor.
module tb_ixc_deposit_logic;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
`ifdef IXC_DEPOSIT_READBACK_EN
    localparam bit RB_EN = 1'b1;
`else
    localparam bit RB_EN = 1'b0;
`endif

    logic             clk;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_op;
    logic [WIDTH-1:0] req_data;
    logic             apply_en;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] dv;
    logic             dv_en;
    logic             ack_valid;
    logic [1:0]       ack_op;
    logic [WIDTH-1:0] rb_data;
    logic             err;

    typedef struct {
        logic [1:0]       op;
        logic [WIDTH-1:0] rb;
        logic             en;
        logic [WIDTH-1:0] dv;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_err    = 0;

    ixc_deposit_logic #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_req_valid (req_valid),
        .o_req_ready (req_ready),
        .i_req_op    (req_op),
        .i_req_data  (req_data),
        .i_apply_en  (apply_en),
        .i_v         (v),
        .o_dv        (dv),
        .o_dv_en     (dv_en),
        .o_ack_valid (ack_valid),
        .o_ack_op    (ack_op),
        .o_rb_data   (rb_data),
        .o_err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [1:0] op, input logic [WIDTH-1:0] d);
        chk("push_ready", 32'(req_ready), 32'(1));
        req_valid = 1'b1;
        req_op    = op;
        req_data  = d;
        tick();
        req_valid = 1'b0;
    endtask

    // One strobe cycle; the expected ack and post-apply override state go to the scoreboard
    task automatic apply(input logic [1:0] op, input logic en, input logic [WIDTH-1:0] exp_dv);
        exp_t e;
        e.op = op;
        e.en = en;
        e.dv = exp_dv;
        e.rb = RB_EN ? v : '0;
        exp_q.push_back(e);
        apply_en = 1'b1;
        tick();
        apply_en = 1'b0;
    endtask

    always @(negedge clk) begin
        if (ack_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_ack: got op=%0d expected no ack at %0t", ack_op, $time);
            end else begin
                mon_e = exp_q.pop_front();
                chk("ack_op", 32'(ack_op), 32'(mon_e.op));
                chk("ack_rb_data", 32'(rb_data), 32'(mon_e.rb));
                chk("ack_dv_en", 32'(dv_en), 32'(mon_e.en));
                chk("ack_dv", 32'(dv), 32'(mon_e.dv));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_op    = 2'b00;
        req_data  = '0;
        apply_en  = 1'b0;
        v         = 8'h5A;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        chk("rst_dv_en", 32'(dv_en), 32'(0));
        chk("rst_dv", 32'(dv), 32'h5A);
        chk("rst_ack_valid", 32'(ack_valid), 32'(0));
        chk("rst_ack_op", 32'(ack_op), 32'(0));
        chk("rst_rb_data", 32'(rb_data), 32'(0));
        chk("rst_err", 32'(err), 32'(0));
        chk("rst_req_ready", 32'(req_ready), 32'(1));

        // Deposit from IDLE: one-cycle pulse
        v = 8'h00;
        push(2'b00, 8'h01);
        tick();
        tick();
        apply(2'b00, 1'b1, 8'h01);
        chk("dep_dv_en_n1", 32'(dv_en), 32'(1));
        chk("dep_dv_n1", 32'(dv), 32'h01);
        tick();
        chk("dep_dv_en_n2", 32'(dv_en), 32'(0));
        chk("dep_dv_n2", 32'(dv), 32'h00);
        tick();
        chk("dep_dv_en_n3", 32'(dv_en), 32'(0));

        // Force held across cycles, then release
        push(2'b01, 8'h01);
        apply(2'b01, 1'b1, 8'h01);
        for (int i = 0; i < 10; i++) begin
            chk("force_hold_en", 32'(dv_en), 32'(1));
            chk("force_hold_dv", 32'(dv), 32'h01);
            tick();
        end
        push(2'b10, 8'hFF);
        chk("force_before_rel", 32'(dv_en), 32'(1));
        apply(2'b10, 1'b0, 8'h00);
        chk("rel_dv_en", 32'(dv_en), 32'(0));
        tick();
        v = 8'h33;
        #1;
        chk("rel_dv_follows_v", 32'(dv), 32'h33);

        // Force, deposit while forced, release on consecutive strobes
        v = 8'h11;
        push(2'b01, 8'hA5);
        push(2'b00, 8'h3C);
        push(2'b10, 8'h00);
        apply(2'b01, 1'b1, 8'hA5);
        chk("frc_dv_a5", 32'(dv), 32'hA5);
        apply(2'b00, 1'b1, 8'h3C);
        chk("frc_dep_dv_3c", 32'(dv), 32'h3C);
        chk("frc_dep_dv_en", 32'(dv_en), 32'(1));
        apply(2'b10, 1'b0, 8'h11);
        chk("frc_rel_dv", 32'(dv), 32'h11);
        tick();

        // Fill the queue, free one slot, refill, drain in order
        push(2'b00, 8'h10);
        push(2'b00, 8'h11);
        push(2'b00, 8'h12);
        push(2'b00, 8'h13);
        chk("full_ready_low", 32'(req_ready), 32'(0));
        apply(2'b00, 1'b1, 8'h10);
        chk("full_ready_back", 32'(req_ready), 32'(1));
        push(2'b00, 8'h14);
        apply(2'b00, 1'b1, 8'h11);
        apply(2'b00, 1'b1, 8'h12);
        apply(2'b00, 1'b1, 8'h13);
        apply(2'b00, 1'b1, 8'h14);
        chk("drain_last_dv", 32'(dv), 32'h14);
        tick();
        chk("drain_end_dv_en", 32'(dv_en), 32'(0));

        // Reserved op sets sticky err; release while idle is ack-only
        push(2'b11, 8'h77);
        apply(2'b11, 1'b0, 8'h11);
        chk("rsv_err", 32'(err), 32'(1));
        chk("rsv_dv_en", 32'(dv_en), 32'(0));
        repeat (3) tick();
        chk("rsv_err_sticky", 32'(err), 32'(1));
        push(2'b10, 8'h00);
        apply(2'b10, 1'b0, 8'h11);
        chk("idle_rel_dv_en", 32'(dv_en), 32'(0));
        chk("idle_rel_err", 32'(err), 32'(1));

        // Reset while forced with entries queued
        push(2'b01, 8'h05);
        apply(2'b01, 1'b1, 8'h05);
        push(2'b00, 8'h06);
        push(2'b00, 8'h07);
        chk("pre_rst_dv_en", 32'(dv_en), 32'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_dv_en", 32'(dv_en), 32'(0));
        chk("mid_rst_dv", 32'(dv), 32'h11);
        chk("mid_rst_err", 32'(err), 32'(0));
        chk("mid_rst_ready", 32'(req_ready), 32'(1));
        chk("mid_rst_rb", 32'(rb_data), 32'(0));
        apply_en = 1'b1;
        repeat (3) tick();
        apply_en = 1'b0;
        tick();
        chk("post_rst_dv_en", 32'(dv_en), 32'(0));
        chk("post_rst_ack", 32'(ack_valid), 32'(0));

        repeat (2) tick();
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
